// File: rtl/vga_frame_buffer_pkg.sv
// vga_pkg: shared geometry, widths and state type for the downscaled frame
// buffer that feeds the VGA timing stage.
//   H_RES/V_RES   visible screen size in screen pixels
//   SCALE_SHIFT   log2 of per-axis pixel replication
//   FB_W/FB_H     stored buffer size; DEPTH = FB_W*FB_H words
//   FB_AW         linear buffer index width
//   FB_XW/FB_YW   write-port coordinate widths
package vga_pkg;

  localparam int H_RES       = 640;
  localparam int V_RES       = 480;
  localparam int SCALE_SHIFT = 2;
  localparam int PIX_W       = 8;

  localparam int FB_W  = H_RES >> SCALE_SHIFT;
  localparam int FB_H  = V_RES >> SCALE_SHIFT;
  localparam int DEPTH = FB_W * FB_H;
  localparam int FB_AW = $clog2(DEPTH);
  localparam int FB_XW = $clog2(FB_W);
  localparam int FB_YW = $clog2(FB_H);

  typedef enum logic {FB_IDLE, FB_CLEAR} fb_state_t;

  // Multiply by a constant as a sum of shifted copies of the operand. With k
  // a parameter every term folds away except the set bits, so this maps to a
  // few adders instead of a hard multiplier.
  function automatic logic [31:0] shift_add_mul(input logic [31:0] a, input int k);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++)
      if (k[i]) acc = acc + (a << i);
    return acc;
  endfunction

endpackage

// File: rtl/vga_frame_buffer_if.sv
// Pixel-write port of the frame buffer (bus-side peripheral -> buffer).
//   WR_VALID/WR_READY  handshake; transfer on VALID && READY
//   WR_X/WR_Y          frame-buffer coordinate of the pixel
//   WR_DATA            pixel value
//   WR_ERR             one-cycle pulse after an out-of-range accepted write
interface vga_frame_buffer_if
  import vga_pkg::*;
#(
  parameter int XW = FB_XW,
  parameter int YW = FB_YW,
  parameter int DW = PIX_W
) ();

  logic          WR_VALID;
  logic          WR_READY;
  logic [XW-1:0] WR_X;
  logic [YW-1:0] WR_Y;
  logic [DW-1:0] WR_DATA;
  logic          WR_ERR;

  modport master (output WR_VALID, WR_X, WR_Y, WR_DATA, input WR_READY, WR_ERR);
  modport slave  (input WR_VALID, WR_X, WR_Y, WR_DATA, output WR_READY, WR_ERR);

endinterface

// File: rtl/vga_frame_buffer_ram.sv
// fb_ram_sdp: simple dual-port RAM, one write port and one synchronous read
// port on the same clock. A read and write to the same address in one cycle
// returns the old contents. No reset on the array so it maps to block RAM.
//   CLK          clock
//   we/waddr/wdata  write port
//   raddr/rdata     read port, rdata valid one cycle after raddr
module fb_ram_sdp #(
  parameter int N_WORDS = 19200,
  parameter int AW      = 15,
  parameter int DW      = 8
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [N_WORDS];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_frame_buffer.sv
// vga_frame_buffer: downscaled frame buffer feeding the VGA stage.
//   CLK, RESET      clock, synchronous active-high reset (also starts a clear)
//   ADDRH/ADDRV     display column/row from the timing stage
//   COLOUR_OUT      pixel colour, two cycles after ADDRH/ADDRV
//   CLR_REQ         level request for a full-buffer clear
//   BUSY            clear engine running
//   wr              pixel-write port (slave side)
// Each stored pixel covers a 2^SCALE_SHIFT square of screen pixels.
module vga_frame_buffer #(
  parameter int              H_RES        = vga_pkg::H_RES,
  parameter int              V_RES        = vga_pkg::V_RES,
  parameter int              SCALE_SHIFT  = vga_pkg::SCALE_SHIFT,
  parameter int              PIX_W        = vga_pkg::PIX_W,
  parameter logic [PIX_W-1:0] CLEAR_COLOUR = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [9:0]       ADDRH,
  input  logic [9:0]       ADDRV,
  output logic [PIX_W-1:0] COLOUR_OUT,
  input  logic             CLR_REQ,
  output logic             BUSY,
  vga_frame_buffer_if.slave wr
);

  localparam int FB_W  = H_RES >> SCALE_SHIFT;
  localparam int FB_H  = V_RES >> SCALE_SHIFT;
  localparam int DEPTH = FB_W * FB_H;
  localparam int FB_AW = $clog2(DEPTH);
  localparam int XW    = $clog2(FB_W);
  localparam int YW    = $clog2(FB_H);

  typedef vga_pkg::fb_state_t state_t;

  state_t             state, state_nx;
  logic [FB_AW-1:0]   clr_cnt, clr_cnt_nx;

  logic               ram_we;
  logic [FB_AW-1:0]   ram_wa;
  logic [PIX_W-1:0]   ram_wd;
  logic [PIX_W-1:0]   ram_q;

  // ---------------------------------------------------------------- write side
  logic               wr_ready, wr_fire, wr_in, wr_err_q;
  logic [FB_AW-1:0]   wr_idx;

  // One extra bit so FB_W/FB_H equal to 2^XW/2^YW still compare correctly.
  assign wr_in  = ({1'b0, wr.WR_X} < (XW+1)'(FB_W)) &&
                  ({1'b0, wr.WR_Y} < (YW+1)'(FB_H));
  assign wr_idx = FB_AW'(vga_pkg::shift_add_mul(32'(wr.WR_Y), FB_W)) +
                  FB_AW'(wr.WR_X);
  assign wr_fire = wr.WR_VALID && wr_ready;

  assign wr.WR_READY = wr_ready;
  assign wr.WR_ERR   = wr_err_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= vga_pkg::FB_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    wr_ready   = 1'b0;
    BUSY       = 1'b0;
    ram_we     = 1'b0;
    ram_wa     = wr_idx;
    ram_wd     = wr.WR_DATA;
    case (state)
      vga_pkg::FB_IDLE: begin
        // A clear request takes priority; a coincident write stays pending.
        wr_ready = !CLR_REQ && !RESET;
        ram_we   = wr_fire && wr_in;
        if (CLR_REQ) state_nx = vga_pkg::FB_CLEAR;
      end
      default: begin
        BUSY   = 1'b1;
        ram_we = !RESET;
        ram_wa = clr_cnt;
        ram_wd = CLEAR_COLOUR;
        if (clr_cnt == FB_AW'(DEPTH - 1)) begin
          state_nx   = vga_pkg::FB_IDLE;
          clr_cnt_nx = '0;
        end else begin
          clr_cnt_nx = clr_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) wr_err_q <= 1'b0;
    else       wr_err_q <= wr_fire && !wr_in;
  end

  // ---------------------------------------------------------------- read side
  // vld_pipe[0]: in-range flag alongside the registered index
  // vld_pipe[1]: same flag aligned with the RAM output
  logic               rd_in;
  logic [FB_AW-1:0]   rd_idx_nx, rd_idx_q;
  logic [1:0]         vld_pipe;

  assign rd_in = ({1'b0, ADDRH} < 11'(H_RES)) && ({1'b0, ADDRV} < 11'(V_RES));

  // Off-screen addresses are forced to index 0 so the RAM is never addressed
  // past DEPTH; their data is masked to zero on the way out.
  assign rd_idx_nx = rd_in
    ? FB_AW'(vga_pkg::shift_add_mul(32'(ADDRV >> SCALE_SHIFT), FB_W)) +
      FB_AW'(ADDRH >> SCALE_SHIFT)
    : '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_pipe <= '0;
      rd_idx_q <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], rd_in};
      rd_idx_q <= rd_idx_nx;
    end
  end

  fb_ram_sdp #(.N_WORDS(DEPTH), .AW(FB_AW), .DW(PIX_W)) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .waddr (ram_wa),
    .wdata (ram_wd),
    .raddr (rd_idx_q),
    .rdata (ram_q)
  );

  assign COLOUR_OUT = vld_pipe[1] ? ram_q : '0;

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Self-checking bench for vga_frame_buffer. Reference: an array of stored
// pixels plus a screen->pixel lookup by integer division.
module tb_vga_frame_buffer;
  import vga_pkg::*;

  localparam int REP = 1 << SCALE_SHIFT;
  localparam int LIM = DEPTH + 1000;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CLR_REQ = 1'b0;
  logic [9:0] ADDRH = '0;
  logic [9:0] ADDRV = '0;
  logic [7:0] COLOUR_OUT;
  logic       BUSY;

  vga_frame_buffer_if wr ();

  always #5 CLK = ~CLK;

  vga_frame_buffer dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ADDRH      (ADDRH),
    .ADDRV      (ADDRV),
    .COLOUR_OUT (COLOUR_OUT),
    .CLR_REQ    (CLR_REQ),
    .BUSY       (BUSY),
    .wr         (wr)
  );

  logic [7:0] mem [DEPTH];
  int n_chk = 0;
  int n_err = 0;
  int qh[$];
  int qv[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int px(input int h, input int v);
    if (h >= H_RES || v >= V_RES) return 0;
    return int'(mem[(v / REP) * FB_W + (h / REP)]);
  endfunction

  task automatic mem_clear();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
  endtask

  // Stream queued addresses one per cycle; each result is due two cycles on.
  task automatic run_reads();
    int n;
    n = qh.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge CLK);
      if (i >= 2)
        chk($sformatf("rd(%0d,%0d)", qh[i-2], qv[i-2]), int'(COLOUR_OUT), px(qh[i-2], qv[i-2]));
      if (i < n) begin
        ADDRH = 10'(qh[i]);
        ADDRV = 10'(qv[i]);
      end
    end
    qh.delete();
    qv.delete();
  endtask

  task automatic push_cell(input int x, input int y);
    qh.push_back(x * REP + int'($urandom_range(0, REP - 1)));
    qv.push_back(y * REP + int'($urandom_range(0, REP - 1)));
  endtask

  // Called on the negedge right after the buffer entered its clear.
  task automatic count_busy(input string tag);
    int n = 0;
    int bad = 0;
    while (BUSY === 1'b1 && n < LIM) begin
      if (wr.WR_READY !== 1'b0) bad++;
      n++;
      @(negedge CLK);
    end
    chk({tag, "_busy_len"}, n, DEPTH);
    chk({tag, "_rdy_low"}, bad, 0);
  endtask

  task automatic wr_px(input int x, input int y, input int d);
    int w = 0;
    int e;
    @(negedge CLK);
    wr.WR_VALID = 1'b1;
    wr.WR_X     = FB_XW'(x);
    wr.WR_Y     = FB_YW'(y);
    wr.WR_DATA  = 8'(d);
    #1;
    while (wr.WR_READY !== 1'b1 && w < LIM) begin
      @(negedge CLK);
      #1;
      w++;
    end
    if (w >= LIM) begin
      chk("wr_timeout", w, 0);
      wr.WR_VALID = 1'b0;
      return;
    end
    @(posedge CLK);
    @(negedge CLK);
    wr.WR_VALID = 1'b0;
    e = (x >= FB_W || y >= FB_H) ? 1 : 0;
    chk($sformatf("wr_err(%0d,%0d)", x, y), int'(wr.WR_ERR), e);
    if (e == 0) mem[y * FB_W + x] = 8'(d);
  endtask

  initial begin
    wr.WR_VALID = 1'b0;
    wr.WR_X = '0;
    wr.WR_Y = '0;
    wr.WR_DATA = '0;
    mem_clear();

    // ---- reset and the clear it triggers
    #1;
    chk("rst_rdy_pre", int'(wr.WR_READY), 0);
    @(negedge CLK);
    chk("rst_rdy", int'(wr.WR_READY), 0);
    chk("rst_busy", int'(BUSY), 1);
    chk("rst_colour", int'(COLOUR_OUT), 0);
    chk("rst_err", int'(wr.WR_ERR), 0);
    RESET = 1'b0;
    count_busy("rst");
    chk("rst_idle_rdy", int'(wr.WR_READY), 1);
    for (int i = 0; i < 4000; i++)
      push_cell(int'($urandom_range(0, FB_W - 1)), int'($urandom_range(0, FB_H - 1)));
    run_reads();

    // ---- replication of one stored pixel over a REPxREP block
    wr_px(10, 5, 'hE3);
    for (int v = 20; v <= 24; v++)
      for (int h = 40; h <= 44; h++) begin
        qh.push_back(h);
        qv.push_back(v);
      end
    run_reads();
    for (int i = 0; i < 25; i++) begin
      qh.push_back(int'($urandom_range(36, 47)));
      qv.push_back(int'($urandom_range(16, 27)));
    end
    run_reads();

    // ---- off-screen reads never alias into the buffer; bad writes are dropped
    wr_px(0, 1, 'h3C);
    qh = '{640, 0, 1023, 639, 2, 640, 3};
    qv = '{0, 4, 479, 480, 5, 4, 1023};
    run_reads();
    wr_px(160, 0, 'h99);
    @(negedge CLK);
    chk("err_single_pulse", int'(wr.WR_ERR), 0);
    wr_px(5, 120, 'h77);
    wr_px(159, 119, 'hA5);
    qh = '{0, 3, 636, 639, 0};
    qv = '{4, 7, 476, 479, 0};
    run_reads();

    // ---- random writes then random reads
    for (int i = 0; i < 300; i++)
      wr_px(int'($urandom_range(0, FB_W + 10)), int'($urandom_range(0, FB_H + 4)),
            int'($urandom_range(0, 255)));
    for (int i = 0; i < 3000; i++) begin
      qh.push_back(int'($urandom_range(0, H_RES + 20)));
      qv.push_back(int'($urandom_range(0, V_RES + 20)));
    end
    run_reads();

    // ---- clear request wins over a coincident write
    @(negedge CLK);
    CLR_REQ = 1'b1;
    wr.WR_VALID = 1'b1;
    wr.WR_X = FB_XW'(3);
    wr.WR_Y = FB_YW'(3);
    wr.WR_DATA = 8'h55;
    #1;
    chk("clr_vs_wr_rdy", int'(wr.WR_READY), 0);
    @(negedge CLK);
    CLR_REQ = 1'b0;
    chk("clr_busy", int'(BUSY), 1);
    count_busy("clr");
    #1;
    chk("held_wr_rdy", int'(wr.WR_READY), 1);
    @(posedge CLK);
    @(negedge CLK);
    wr.WR_VALID = 1'b0;
    chk("held_wr_err", int'(wr.WR_ERR), 0);
    mem_clear();
    mem[3 * FB_W + 3] = 8'h55;
    for (int v = 11; v <= 16; v++)
      for (int h = 11; h <= 16; h++) begin
        qh.push_back(h);
        qv.push_back(v);
      end
    for (int i = 0; i < 500; i++)
      push_cell(int'($urandom_range(0, FB_W - 1)), int'($urandom_range(0, FB_H - 1)));
    run_reads();

    // ---- read-first on a same-cycle read/write collision
    wr_px(7, 7, 'h11);
    @(negedge CLK);
    ADDRH = 10'd29;
    ADDRV = 10'd30;
    @(negedge CLK);
    wr.WR_VALID = 1'b1;
    wr.WR_X = FB_XW'(7);
    wr.WR_Y = FB_YW'(7);
    wr.WR_DATA = 8'h22;
    #1;
    chk("col_rdy", int'(wr.WR_READY), 1);
    @(negedge CLK);
    wr.WR_VALID = 1'b0;
    chk("col_old", int'(COLOUR_OUT), 'h11);
    @(negedge CLK);
    chk("col_new", int'(COLOUR_OUT), 'h22);
    mem[7 * FB_W + 7] = 8'h22;

    // ---- fill with random data, then reset 1000 cycles into a clear
    for (int i = 0; i < 200; i++)
      wr_px(int'($urandom_range(0, FB_W - 1)), int'($urandom_range(0, FB_H - 1)),
            int'($urandom_range(1, 255)));
    @(negedge CLK);
    CLR_REQ = 1'b1;
    @(negedge CLK);
    CLR_REQ = 1'b0;
    repeat (999) @(negedge CLK);
    chk("mid_busy", int'(BUSY), 1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    count_busy("mid");
    mem_clear();
    for (int y = 0; y < FB_H; y++)
      for (int x = 0; x < FB_W; x++)
        push_cell(x, y);
    run_reads();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
